// File: rtl/denise_spr_pkg.sv
// rtl/denise_spr_pkg.sv - register map, fetch-width encodings and channel state for the sprite engine
// Shared by denise_sprite_channel and denise_sprite_engine.
//   SPR_BANK   : reg_address_in[7:5] value selecting the sprite register bank (9'h140..9'h17E)
//   REG_*      : per-channel register offsets in reg_address_in[1:0]
//   SPRW_*     : sprw fetch-width encodings
//   width()    : fetch width in bits for a sprw code, clamped to the widest supported fetch
//   clx_index(): bit position of collision flag (i,j), i<j, in the packed pair-collision vector
package denise_spr_pkg;

    localparam logic [2:0] SPR_BANK = 3'b101;

    localparam logic [1:0] REG_POS  = 2'd0;
    localparam logic [1:0] REG_CTL  = 2'd1;
    localparam logic [1:0] REG_DATA = 2'd2;
    localparam logic [1:0] REG_DATB = 2'd3;

    localparam logic [1:0] SPRW_16  = 2'b00;
    localparam logic [1:0] SPRW_16B = 2'b01;
    localparam logic [1:0] SPRW_32  = 2'b10;
    localparam logic [1:0] SPRW_64  = 2'b11;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        SHIFT    = 2'd2
    } chan_state_t;

    function automatic logic [6:0] width(input logic [1:0] sprw, input int maxw);
        logic [6:0] w;
        case (sprw)
            SPRW_16, SPRW_16B: w = 7'd16;
            SPRW_32:           w = 7'd32;
            SPRW_64:           w = 7'd64;
            default:           w = 7'd16;
        endcase
        if (int'(w) > maxw) begin
            w = 7'(maxw);
        end
        return w;
    endfunction

    // Flags are packed in the order (0,1),(0,2)..(0,n-1),(1,2)..
    function automatic int clx_index(input int i, input int j, input int n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/denise_sprite_channel.sv
// rtl/denise_sprite_channel.sv - one sprite channel: register decode, holding regs, shifters and arm FSM
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clk7_en, shift_en     : 7MHz state enable, pixel shift strobe
//   reg_address_in        : register address [8:1]; a match on this channel's slot is a write
//   data_in, chip48       : bus word plus extra fetch bits, concatenated for wide fetches
//   hpos                  : beam position compared against HSTART
//   sprw                  : fetch width code
//   pixel                 : {DATB msb, DATA msb} while shifting, else 0
//   attach                : CTL[7]
module denise_sprite_channel
    import denise_spr_pkg::*;
#(
    parameter int CHAN   = 0,
    parameter int MAXW   = 64,
    parameter int HPOS_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk7_en,
    input  logic              shift_en,
    input  logic [7:0]        reg_address_in,
    input  logic [15:0]       data_in,
    input  logic [47:0]       chip48,
    input  logic [HPOS_W-1:0] hpos,
    input  logic [1:0]        sprw,
    output logic [1:0]        pixel,
    output logic              attach
);

    chan_state_t       state_q, state_d;
    logic              keep_arm_q, keep_arm_d;
    logic [7:0]        pos_q;
    logic              ctl0_q;
    logic              attach_q;
    logic [MAXW-1:0]   hold_a_q, hold_b_q;
    logic [MAXW-1:0]   shf_a_q, shf_b_q;
    logic [MAXW-1:0]   hold_new, mask;
    logic [6:0]        bitcnt_q, w;
    logic [63:0]       bus_word;
    logic [HPOS_W-1:0] hstart;
    logic              sel, wr_pos, wr_ctl, wr_data, wr_datb;
    logic              arm_now, arm_eff, load, shift, last;

    assign sel     = clk7_en && (reg_address_in[7:5] == SPR_BANK) && (reg_address_in[4:2] == 3'(CHAN));
    assign wr_pos  = sel && (reg_address_in[1:0] == REG_POS);
    assign wr_ctl  = sel && (reg_address_in[1:0] == REG_CTL);
    assign wr_data = sel && (reg_address_in[1:0] == REG_DATA);
    assign wr_datb = sel && (reg_address_in[1:0] == REG_DATB);

    assign w        = width(sprw, MAXW);
    assign bus_word = {data_in, chip48};

    // Keep only the top w bits of the fetch so narrow sprites shift out zeros past their end.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAXW; i++) begin
            mask[i] = (i >= MAXW - int'(w));
        end
    end

    assign hold_new = bus_word[63 -: MAXW] & mask;
    assign hstart   = HPOS_W'({pos_q, ctl0_q});
    assign attach   = attach_q;
    assign pixel    = (state_q == SHIFT) ? {shf_b_q[MAXW-1], shf_a_q[MAXW-1]} : 2'b00;

    // keep_arm records whether the channel returns to ARMED when the current sprite ends;
    // a CTL write mid-shift clears it so the sprite finishes but does not retrigger.
    always_comb begin
        arm_now = (state_q == ARMED) || ((state_q == SHIFT) && keep_arm_q);
        arm_eff = arm_now;
        if (wr_data) begin
            arm_eff = 1'b1;
        end else if (wr_ctl) begin
            arm_eff = 1'b0;
        end
        load       = clk7_en && arm_eff && (hpos == hstart);
        shift      = clk7_en && (state_q == SHIFT) && shift_en && !load;
        last       = shift && (bitcnt_q == 7'd1);
        state_d    = state_q;
        keep_arm_d = keep_arm_q;
        if (clk7_en) begin
            keep_arm_d = arm_eff;
            if (load) begin
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                if (last) begin
                    state_d = arm_eff ? ARMED : DISARMED;
                end
            end else begin
                state_d = arm_eff ? ARMED : DISARMED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DISARMED;
            keep_arm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            keep_arm_q <= keep_arm_d;
        end
    end

    // A DATA/DATB write coinciding with the HSTART match loads the new word directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q    <= '0;
            ctl0_q   <= 1'b0;
            attach_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            shf_a_q  <= '0;
            shf_b_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            if (wr_pos) begin
                pos_q <= data_in[7:0];
            end
            if (wr_ctl) begin
                ctl0_q   <= data_in[0];
                attach_q <= data_in[7];
            end
            if (wr_data) begin
                hold_a_q <= hold_new;
            end
            if (wr_datb) begin
                hold_b_q <= hold_new;
            end
            if (load) begin
                shf_a_q  <= wr_data ? hold_new : hold_a_q;
                shf_b_q  <= wr_datb ? hold_new : hold_b_q;
                bitcnt_q <= w;
            end else if (shift) begin
                shf_a_q  <= shf_a_q << 1;
                shf_b_q  <= shf_b_q << 1;
                bitcnt_q <= bitcnt_q - 7'd1;
            end
        end
    end

endmodule

// File: rtl/denise_sprite_engine.sv
// rtl/denise_sprite_engine.sv - sprite engine: channel array, pair priority, attach and pair collisions
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   clk7_en, shift_en     : 7MHz state enable, pixel shift strobe
//   reg_address_in        : register address [8:1]
//   data_in, chip48       : bus word and extra fetch bits
//   hpos                  : horizontal beam position
//   sprw, aga, sprena     : fetch width, AGA attach rule, global sprite enable
//   esprm, osprm          : even/odd colour bank bits
//   clx_clr               : clear collision flags
//   sprdata               : registered colour index of the winning sprite pixel
//   nsprite               : registered per-channel opaque flags
//   sprclx                : sticky pair-to-pair collision flags
module denise_sprite_engine
    import denise_spr_pkg::*;
#(
    parameter int  NUM_PAIRS = 4,
    parameter int  MAXW      = 64,
    parameter int  HPOS_W    = 9,
    localparam int NCH       = 2 * NUM_PAIRS,
    localparam int CLX_W     = (NUM_PAIRS > 1) ? NUM_PAIRS * (NUM_PAIRS - 1) / 2 : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk7_en,
    input  logic              shift_en,
    input  logic [7:0]        reg_address_in,
    input  logic [15:0]       data_in,
    input  logic [47:0]       chip48,
    input  logic [HPOS_W-1:0] hpos,
    input  logic [1:0]        sprw,
    input  logic              aga,
    input  logic              sprena,
    input  logic [3:0]        esprm,
    input  logic [3:0]        osprm,
    input  logic              clx_clr,
    output logic [7:0]        sprdata,
    output logic [NCH-1:0]    nsprite,
    output logic [CLX_W-1:0]  sprclx
);

    logic [1:0]           pix [NCH];
    logic [NCH-1:0]       att;
    logic [NUM_PAIRS-1:0] pair_hit;
    logic [CLX_W-1:0]     clx_set;
    logic [NCH-1:0]       nspr_d;
    logic [7:0]           sprdata_d;
    logic                 found;

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        denise_sprite_channel #(
            .CHAN   (n),
            .MAXW   (MAXW),
            .HPOS_W (HPOS_W)
        ) u_chan (
            .clk            (clk),
            .reset          (reset),
            .clk7_en        (clk7_en),
            .shift_en       (shift_en),
            .reg_address_in (reg_address_in),
            .data_in        (data_in),
            .chip48         (chip48),
            .hpos           (hpos),
            .sprw           (sprw),
            .pixel          (pix[n]),
            .attach         (att[n])
        );
    end

    // Collisions use raw pair pixels, independent of the output enable.
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        assign pair_hit[p] = (pix[2*p] != 2'b00) || (pix[2*p+1] != 2'b00);
    end

    if (NUM_PAIRS == 1) begin : g_no_clx
        assign clx_set = '0;
    end else begin : g_clx
        for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_i
            for (genvar j = i + 1; j < NUM_PAIRS; j++) begin : g_j
                assign clx_set[clx_index(i, j, NUM_PAIRS)] = pair_hit[i] && pair_hit[j];
            end
        end
    end

    // Lowest-numbered pair with a visible pixel wins; within it an attached pair
    // forms a 4-bit colour, otherwise the even channel beats the odd one.
    always_comb begin
        nspr_d    = '0;
        sprdata_d = 8'h00;
        found     = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            nspr_d[n] = sprena && (pix[n] != 2'b00);
        end
        for (int p = 0; p < NUM_PAIRS; p++) begin
            if (!found && (nspr_d[2*p] || nspr_d[2*p+1])) begin
                found = 1'b1;
                if (att[2*p+1] || (!aga && att[2*p])) begin
                    sprdata_d = {osprm, pix[2*p+1], pix[2*p]};
                end else if (pix[2*p] != 2'b00) begin
                    sprdata_d = {esprm, 2'(p), pix[2*p]};
                end else begin
                    sprdata_d = {osprm, 2'(p), pix[2*p+1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sprdata <= 8'h00;
            nsprite <= '0;
            sprclx  <= '0;
        end else if (clk7_en) begin
            sprdata <= sprdata_d;
            nsprite <= nspr_d;
            sprclx  <= clx_clr ? '0 : (sprclx | clx_set);
        end
    end

endmodule

// File: tb/tb_denise_sprite_engine.sv
// tb/tb_denise_sprite_engine.sv - self-checking bench for denise_sprite_engine
module tb_denise_sprite_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk7_en = 1'b0;
    logic        shift_en = 1'b0;
    logic [7:0]  reg_address_in = 8'hFF;
    logic [15:0] data_in = 16'h0;
    logic [47:0] chip48 = 48'h0;
    logic [8:0]  hpos = 9'h0;
    logic [1:0]  sprw = 2'b00;
    logic        aga = 1'b0;
    logic        sprena = 1'b1;
    logic [3:0]  esprm = 4'h0;
    logic [3:0]  osprm = 4'h0;
    logic        clx_clr = 1'b0;
    logic [7:0]  sprdata;
    logic [7:0]  nsprite;
    logic [5:0]  sprclx;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    denise_sprite_engine #(.NUM_PAIRS(4), .MAXW(64), .HPOS_W(9)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .shift_en       (shift_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .chip48         (chip48),
        .hpos           (hpos),
        .sprw           (sprw),
        .aga            (aga),
        .sprena         (sprena),
        .esprm          (esprm),
        .osprm          (osprm),
        .clx_clr        (clx_clr),
        .sprdata        (sprdata),
        .nsprite        (nsprite),
        .sprclx         (sprclx)
    );

    // Reference model: each channel holds a list of pending pixels and a cursor into it.
    logic [7:0]  m_posb [8];
    logic        m_ctl0 [8];
    logic        m_att  [8];
    logic        m_arm  [8];
    logic [63:0] m_ha   [8];
    logic [63:0] m_hb   [8];
    logic [1:0]  m_pix  [8][64];
    int          m_pos  [8];
    int          m_len  [8];
    logic [7:0]  e_sprdata;
    logic [7:0]  e_nspr;
    logic [5:0]  e_clx;

    function automatic int wd(input logic [1:0] code);
        if (code == 2'b11) return 64;
        if (code == 2'b10) return 32;
        return 16;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 8; c++) begin
            m_posb[c] = 8'h0; m_ctl0[c] = 1'b0; m_att[c] = 1'b0; m_arm[c] = 1'b0;
            m_ha[c] = 64'h0; m_hb[c] = 64'h0; m_pos[c] = 0; m_len[c] = 0;
        end
        e_sprdata = 8'h0; e_nspr = 8'h0; e_clx = 6'h0;
    endtask

    task automatic model_step();
        logic [1:0]  cur [8];
        logic [7:0]  ns;
        logic [3:0]  pnz;
        logic [5:0]  cs;
        logic [7:0]  sd;
        logic [7:0]  mt;
        logic        found;
        logic [63:0] full;
        logic [63:0] hv;
        int          k;
        int          w;
        int          ch;
        for (int c = 0; c < 8; c++) begin
            cur[c] = (m_pos[c] < m_len[c]) ? m_pix[c][m_pos[c]] : 2'b00;
        end
        ns = 8'h0;
        for (int c = 0; c < 8; c++) ns[c] = sprena && (cur[c] != 2'b00);
        sd = 8'h0;
        found = 1'b0;
        for (int p = 0; p < 4; p++) begin
            pnz[p] = (cur[2*p] != 2'b00) || (cur[2*p+1] != 2'b00);
            if (!found && (ns[2*p] || ns[2*p+1])) begin
                found = 1'b1;
                if (m_att[2*p+1] || (!aga && m_att[2*p])) sd = {osprm, cur[2*p+1], cur[2*p]};
                else if (cur[2*p] != 2'b00) sd = {esprm, 2'(p), cur[2*p]};
                else sd = {osprm, 2'(p), cur[2*p+1]};
            end
        end
        cs = 6'h0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (pnz[i] && pnz[j]) cs[k] = 1'b1;
                k++;
            end
        end
        e_sprdata = sd;
        e_nspr = ns;
        e_clx = clx_clr ? 6'h0 : (e_clx | cs);
        for (int c = 0; c < 8; c++) mt[c] = (hpos == {m_posb[c], m_ctl0[c]});
        w = wd(sprw);
        full = {data_in, chip48};
        hv = (full >> (64 - w)) << (64 - w);
        if (reg_address_in[7:5] == 3'b101) begin
            ch = int'(reg_address_in[4:2]);
            case (reg_address_in[1:0])
                2'd0: m_posb[ch] = data_in[7:0];
                2'd1: begin m_ctl0[ch] = data_in[0]; m_att[ch] = data_in[7]; m_arm[ch] = 1'b0; end
                2'd2: begin m_ha[ch] = hv; m_arm[ch] = 1'b1; end
                default: m_hb[ch] = hv;
            endcase
        end
        for (int c = 0; c < 8; c++) begin
            if (m_arm[c] && mt[c]) begin
                for (int b = 0; b < w; b++) m_pix[c][b] = {m_hb[c][63-b], m_ha[c][63-b]};
                m_pos[c] = 0;
                m_len[c] = w;
            end else if (m_pos[c] < m_len[c] && shift_en) begin
                m_pos[c]++;
            end
        end
    endtask

    // One 7MHz slot: enable high for one clk, low for three; inputs held throughout.
    task automatic tick();
        model_step();
        clk7_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk7_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] ch, input logic [1:0] rg, input logic [15:0] d);
        reg_address_in = {3'b101, ch, rg};
        data_in = d;
        tick();
        reg_address_in = 8'hFF;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk7_en = 1'b0;
        reg_address_in = 8'hFF;
        clx_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (sprdata !== 8'h00) begin bad++; $display("FAIL reset_sprdata got=%h exp=00", sprdata); end
        total++; if (nsprite !== 8'h00) begin bad++; $display("FAIL reset_nsprite got=%h exp=00", nsprite); end
        total++; if (sprclx !== 6'h00) begin bad++; $display("FAIL reset_sprclx got=%h exp=00", sprclx); end
    endtask

    task automatic test_basic16();
        int cnt = 0;
        int first = -1;
        int lastp = -1;
        logic [7:0] first_sd = 8'h0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b00; hpos = 9'h0;
        esprm = 4'($urandom); osprm = 4'($urandom); chip48 = {$urandom, 16'($urandom)};
        wr(3'd0, 2'd0, 16'h0040);
        wr(3'd0, 2'd1, 16'h0000);
        wr(3'd0, 2'd3, 16'h0000);
        wr(3'd0, 2'd2, 16'h8001);
        for (int i = 0; i < 24; i++) begin
            hpos = 9'(9'h7E + i);
            tick();
            total++;
            if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                bad++; $display("FAIL basic16 hpos=%h got=%h exp=%h", hpos, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
            end
            if (nsprite[0]) begin
                cnt++;
                if (first < 0) begin first = int'(hpos); first_sd = sprdata; end
                lastp = int'(hpos);
            end
        end
        total++; if (first != 'h81) begin bad++; $display("FAIL basic16_first got=%0h exp=81", first); end
        total++; if (lastp != 'h90) begin bad++; $display("FAIL basic16_last got=%0h exp=90", lastp); end
        total++; if (cnt != 2) begin bad++; $display("FAIL basic16_count got=%0d exp=2", cnt); end
        total++; if (first_sd !== {esprm, 2'b00, 2'b01}) begin bad++; $display("FAIL basic16_sprdata got=%h exp=%h", first_sd, {esprm, 4'b0001}); end
    endtask

    task automatic test_width64();
        int cnt = 0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b11; hpos = 9'h0; chip48 = 48'hFFFF_FFFF_FFFF;
        wr(3'd3, 2'd0, 16'h0010);
        wr(3'd3, 2'd1, 16'h0000);
        wr(3'd3, 2'd2, 16'hFFFF);
        for (int i = 0; i < 80; i++) begin
            hpos = 9'(9'h1E + i);
            tick();
            total++;
            if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                bad++; $display("FAIL width64 hpos=%h got=%h exp=%h", hpos, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
            end
            if (nsprite[3]) cnt++;
        end
        total++; if (cnt != 64) begin bad++; $display("FAIL width64_count got=%0d exp=64", cnt); end
        total++; if (nsprite !== 8'h00) begin bad++; $display("FAIL width64_idle got=%h exp=00", nsprite); end
    endtask

    task automatic test_attach();
        logic [7:0] seen = 8'h0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b00; aga = 1'b1; hpos = 9'h0; chip48 = 48'h0;
        osprm = 4'($urandom); esprm = 4'($urandom);
        wr(3'd0, 2'd0, 16'h0020); wr(3'd0, 2'd1, 16'h0000); wr(3'd0, 2'd2, 16'hFFFF);
        wr(3'd1, 2'd0, 16'h0020); wr(3'd1, 2'd1, 16'h0080); wr(3'd1, 2'd2, 16'h0000);
        wr(3'd1, 2'd3, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            hpos = 9'(9'h3F + i);
            tick();
            total++;
            if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                bad++; $display("FAIL attach hpos=%h got=%h exp=%h", hpos, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
            end
            if (hpos == 9'h41) seen = sprdata;
        end
        total++; if (seen !== {osprm, 2'b10, 2'b01}) begin bad++; $display("FAIL attach_sprdata got=%h exp=%h", seen, {osprm, 4'b1001}); end
        aga = 1'b0;
    endtask

    task automatic test_priority();
        logic [7:0] seen_sd = 8'h0;
        logic [5:0] seen_clx = 6'h0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b00; hpos = 9'h0; chip48 = 48'h0;
        esprm = 4'($urandom); osprm = 4'($urandom);
        wr(3'd2, 2'd0, 16'h0030); wr(3'd2, 2'd1, 16'h0000); wr(3'd2, 2'd2, 16'hFFFF);
        wr(3'd5, 2'd0, 16'h0030); wr(3'd5, 2'd1, 16'h0000); wr(3'd5, 2'd2, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            hpos = 9'(9'h5F + i);
            tick();
            total++;
            if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                bad++; $display("FAIL priority hpos=%h got=%h exp=%h", hpos, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
            end
            if (hpos == 9'h61) begin seen_sd = sprdata; seen_clx = sprclx; end
        end
        total++; if (seen_sd !== {esprm, 2'b01, 2'b01}) begin bad++; $display("FAIL priority_sprdata got=%h exp=%h", seen_sd, {esprm, 4'b0101}); end
        total++; if (seen_clx !== 6'b001000) begin bad++; $display("FAIL priority_clx got=%b exp=001000", seen_clx); end
        total++; if (sprclx !== 6'b001000) begin bad++; $display("FAIL clx_sticky got=%b exp=001000", sprclx); end
        clx_clr = 1'b1;
        tick();
        clx_clr = 1'b0;
        total++; if (sprclx !== 6'b000000) begin bad++; $display("FAIL clx_clear got=%b exp=000000", sprclx); end
    endtask

    task automatic test_ctl_midshift();
        int cnt1 = 0;
        int cnt2 = 0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b00; hpos = 9'h0; chip48 = 48'h0;
        wr(3'd4, 2'd0, 16'h0050); wr(3'd4, 2'd1, 16'h0000);
        wr(3'd4, 2'd3, 16'h5555); wr(3'd4, 2'd2, 16'hAAAA);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 22; i++) begin
                hpos = 9'(9'h9F + i);
                data_in = 16'h0000;
                reg_address_in = (pass == 0 && hpos == 9'hA5) ? {3'b101, 3'd4, 2'd1} : 8'hFF;
                tick();
                reg_address_in = 8'hFF;
                total++;
                if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                    bad++; $display("FAIL ctl_mid hpos=%h got=%h exp=%h", hpos, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
                end
                if (nsprite[4]) begin
                    if (pass == 0) cnt1++; else cnt2++;
                end
            end
        end
        total++; if (cnt1 != 16) begin bad++; $display("FAIL ctl_mid_complete got=%0d exp=16", cnt1); end
        total++; if (cnt2 != 0) begin bad++; $display("FAIL ctl_mid_retrigger got=%0d exp=0", cnt2); end
    endtask

    task automatic test_reset_midshift();
        int cnt = 0;
        do_reset();
        shift_en = 1'b1; sprw = 2'b00; hpos = 9'h0; chip48 = 48'h0;
        wr(3'd0, 2'd0, 16'h0040); wr(3'd0, 2'd1, 16'h0000); wr(3'd0, 2'd2, 16'hFFFF);
        for (int i = 0; i < 7; i++) begin
            hpos = 9'(9'h7F + i);
            tick();
        end
        total++; if (nsprite[0] !== 1'b1) begin bad++; $display("FAIL rst_mid_active got=%b exp=1", nsprite[0]); end
        do_reset();
        total++; if (sprdata !== 8'h00) begin bad++; $display("FAIL rst_mid_sprdata got=%h exp=00", sprdata); end
        total++; if (nsprite !== 8'h00) begin bad++; $display("FAIL rst_mid_nsprite got=%h exp=00", nsprite); end
        for (int i = 0; i < 24; i++) begin
            hpos = 9'(9'h7E + i);
            tick();
            if (nsprite != 8'h00 || sprdata != 8'h00) cnt++;
        end
        total++; if (cnt != 0) begin bad++; $display("FAIL rst_mid_rearm got=%0d exp=0", cnt); end
    endtask

    task automatic test_random();
        logic [1:0] rg;
        do_reset();
        hpos = 9'h0;
        for (int i = 0; i < 800; i++) begin
            hpos = (hpos + 9'd1) & 9'h01F;
            shift_en = ($urandom_range(0, 3) != 0);
            sprena = ($urandom_range(0, 19) != 0);
            clx_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 49) == 0) sprw = 2'($urandom);
            if ($urandom_range(0, 49) == 0) aga = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin esprm = 4'($urandom); osprm = 4'($urandom); end
            data_in = 16'($urandom);
            chip48 = {$urandom, 16'($urandom)};
            reg_address_in = 8'hFF;
            case ($urandom_range(0, 5))
                0, 1: begin
                    rg = 2'($urandom);
                    if (rg == 2'd0) data_in[7:4] = 4'h0;
                    reg_address_in = {3'b101, 3'($urandom), rg};
                end
                2: reg_address_in = 8'($urandom);
                default: reg_address_in = 8'hFF;
            endcase
            tick();
            reg_address_in = 8'hFF;
            total++;
            if ({sprdata, nsprite, sprclx} !== {e_sprdata, e_nspr, e_clx}) begin
                bad++; $display("FAIL random i=%0d got=%h exp=%h", i, {sprdata, nsprite, sprclx}, {e_sprdata, e_nspr, e_clx});
            end
        end
        sprena = 1'b1; clx_clr = 1'b0; aga = 1'b0; sprw = 2'b00;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic16();
        test_width64();
        test_attach();
        test_priority();
        test_ctl_midshift();
        test_reset_midshift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
